// File: rtl/sd_sched_pkg.sv
// Shared state encoding and constants for the SD frame fetch scheduler.
package sd_sched_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWaitBank,
      StIssue,
      StRecv,
      StRetry,
      StNext,
      StDone,
      StFault
   } state_e;

   localparam int unsigned BlockBytes = 512;

endpackage

// File: rtl/sd_block_addr_gen.sv
// Frame/block position tracker: holds frame_index and blk_cnt and forms the SD block address.
module sd_block_addr_gen #(
   parameter int unsigned START_BLOCK      = 0,
   parameter int unsigned BLOCKS_PER_FRAME = 2,
   parameter int unsigned NUM_FRAMES       = 6572,
   parameter int unsigned LOOP             = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        blk_inc_i,
   input  logic        frame_adv_i,
   output logic [7:0]  blk_cnt_o,
   output logic [15:0] frame_index_o,
   output logic [31:0] addr_o,
   output logic        last_blk_o,
   output logic        last_frame_o
);

   localparam logic [7:0]  LastBlk   = 8'(BLOCKS_PER_FRAME - 1);
   localparam logic [15:0] LastFrame = 16'(NUM_FRAMES - 1);

   logic [7:0]  blk_q;
   logic [15:0] frame_q;

   assign last_blk_o    = (blk_q == LastBlk);
   assign last_frame_o  = (frame_q == LastFrame);
   assign blk_cnt_o     = blk_q;
   assign frame_index_o = frame_q;
   assign addr_o        = 32'(START_BLOCK) + 32'(frame_q) * 32'(BLOCKS_PER_FRAME) + 32'(blk_q);

   // Without LOOP the last frame index is held so DONE still reports it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         blk_q   <= '0;
         frame_q <= '0;
      end else if (frame_adv_i) begin
         blk_q <= '0;
         if (!last_frame_o) begin
            frame_q <= frame_q + 16'd1;
         end else if (LOOP != 0) begin
            frame_q <= '0;
         end
      end else if (blk_inc_i) begin
         blk_q <= blk_q + 8'd1;
      end
   end

endmodule

// File: rtl/sd_frame_fetch_sched.sv
// Streams video frames from SD single-block reads into a ping-pong frame buffer,
// paced by display-side bank releases, with per-block retry and sticky fault.
module sd_frame_fetch_sched
   import sd_sched_pkg::*;
#(
   parameter int unsigned START_BLOCK      = 0,
   parameter int unsigned BLOCKS_PER_FRAME = 2,
   parameter int unsigned NUM_FRAMES       = 6572,
   parameter int unsigned LOOP             = 1,
   parameter int unsigned MAX_RETRIES      = 3,
   parameter int unsigned BUF_ADDR_W       = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sd_ready,
   output logic                  rd_req,
   output logic [31:0]           rd_addr,
   input  logic                  rd_ack,
   input  logic [7:0]            rd_data,
   input  logic                  rd_data_valid,
   input  logic                  rd_done,
   input  logic                  rd_error,
   output logic                  buf_we,
   output logic                  buf_bank,
   output logic [BUF_ADDR_W-1:0] buf_addr,
   output logic [7:0]            buf_wdata,
   output logic [1:0]            bank_full,
   input  logic [1:0]            bank_release,
   output logic [15:0]           frame_index,
   output logic                  playing,
   output logic                  fault
);

   localparam logic [7:0] MaxRetries = 8'(MAX_RETRIES);
   localparam logic [8:0] LastByte   = 9'(BlockBytes - 1);

   state_e                state_q;
   logic                  bank_ptr_q;
   logic [1:0]            bank_full_q;
   logic [7:0]            retry_q;
   logic [8:0]            byte_cnt_q;
   logic                  blk_full_q;
   logic                  overrun_q;
   logic                  rd_req_q;
   logic                  fault_q;
   logic                  playing_q;
   logic                  buf_we_q;
   logic                  buf_bank_q;
   logic [BUF_ADDR_W-1:0] buf_addr_q;
   logic [7:0]            buf_wdata_q;

   logic [7:0]  blk_cnt;
   logic [31:0] blk_addr;
   logic        last_blk;
   logic        last_frame;
   logic        blk_inc;
   logic        frame_adv;
   logic        blk_good;
   logic [BUF_ADDR_W-1:0] wr_addr;

   assign blk_inc   = (state_q == StNext) && !last_blk;
   assign frame_adv = (state_q == StNext) && last_blk;
   // byte_cnt wraps to 0 after 512 bytes; blk_full_q marks the full block.
   assign blk_good  = blk_full_q && !overrun_q;
   assign wr_addr   = BUF_ADDR_W'(32'(blk_cnt) * BlockBytes + 32'(byte_cnt_q));

   sd_block_addr_gen #(
      .START_BLOCK      (START_BLOCK),
      .BLOCKS_PER_FRAME (BLOCKS_PER_FRAME),
      .NUM_FRAMES       (NUM_FRAMES),
      .LOOP             (LOOP)
   ) u_addr_gen (
      .clk_i         (clk),
      .rst_ni        (reset),
      .blk_inc_i     (blk_inc),
      .frame_adv_i   (frame_adv),
      .blk_cnt_o     (blk_cnt),
      .frame_index_o (frame_index),
      .addr_o        (blk_addr),
      .last_blk_o    (last_blk),
      .last_frame_o  (last_frame)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         bank_ptr_q  <= 1'b0;
         bank_full_q <= '0;
         retry_q     <= '0;
         byte_cnt_q  <= '0;
         blk_full_q  <= 1'b0;
         overrun_q   <= 1'b0;
         rd_req_q    <= 1'b0;
         fault_q     <= 1'b0;
         playing_q   <= 1'b0;
         buf_we_q    <= 1'b0;
         buf_bank_q  <= 1'b0;
         buf_addr_q  <= '0;
         buf_wdata_q <= '0;
      end else begin
         buf_we_q <= 1'b0;
         // Releases first so a set on the same bank below takes priority.
         for (int i = 0; i < 2; i++) begin
            if (bank_release[i]) begin
               bank_full_q[i] <= 1'b0;
            end
         end
         case (state_q)
            StIdle: begin
               if (sd_ready) begin
                  state_q   <= StWaitBank;
                  playing_q <= 1'b1;
               end
            end
            StWaitBank: begin
               if (!bank_full_q[bank_ptr_q]) begin
                  state_q    <= StIssue;
                  rd_req_q   <= 1'b1;
                  byte_cnt_q <= '0;
                  blk_full_q <= 1'b0;
                  overrun_q  <= 1'b0;
               end
            end
            StIssue: begin
               if (rd_ack) begin
                  rd_req_q <= 1'b0;
                  state_q  <= StRecv;
               end
            end
            StRecv: begin
               if (rd_data_valid) begin
                  if (blk_full_q) begin
                     overrun_q <= 1'b1;
                  end else begin
                     buf_we_q    <= 1'b1;
                     buf_bank_q  <= bank_ptr_q;
                     buf_addr_q  <= wr_addr;
                     buf_wdata_q <= rd_data;
                     byte_cnt_q  <= byte_cnt_q + 9'd1;
                     if (byte_cnt_q == LastByte) begin
                        blk_full_q <= 1'b1;
                     end
                  end
               end
               if (rd_error || (rd_done && !blk_good)) begin
                  state_q <= StRetry;
               end else if (rd_done) begin
                  state_q <= StNext;
               end
            end
            StRetry: begin
               if (retry_q < MaxRetries) begin
                  retry_q    <= retry_q + 8'd1;
                  byte_cnt_q <= '0;
                  blk_full_q <= 1'b0;
                  overrun_q  <= 1'b0;
                  rd_req_q   <= 1'b1;
                  state_q    <= StIssue;
               end else begin
                  fault_q   <= 1'b1;
                  playing_q <= 1'b0;
                  state_q   <= StFault;
               end
            end
            StNext: begin
               retry_q <= '0;
               if (!last_blk) begin
                  byte_cnt_q <= '0;
                  blk_full_q <= 1'b0;
                  overrun_q  <= 1'b0;
                  rd_req_q   <= 1'b1;
                  state_q    <= StIssue;
               end else begin
                  bank_full_q[bank_ptr_q] <= 1'b1;
                  bank_ptr_q              <= ~bank_ptr_q;
                  if (last_frame && (LOOP == 0)) begin
                     playing_q <= 1'b0;
                     state_q   <= StDone;
                  end else begin
                     state_q <= StWaitBank;
                  end
               end
            end
            StDone, StFault: begin
               rd_req_q <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign rd_req    = rd_req_q;
   assign rd_addr   = rd_req_q ? blk_addr : '0;
   assign buf_we    = buf_we_q;
   assign buf_bank  = buf_bank_q;
   assign buf_addr  = buf_addr_q;
   assign buf_wdata = buf_wdata_q;
   assign bank_full = bank_full_q;
   assign playing   = playing_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_sd_frame_fetch_sched.sv
// Directed bench: instance A (LOOP=0, 3 frames) and instance B (LOOP=1, 2 frames), one observed at a time.
module tb_sd_frame_fetch_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_a, reset_b, sd_ready_a, sd_ready_b, sel;
   logic        rd_ack, rd_data_valid, rd_done, rd_error;
   logic [7:0]  rd_data;
   logic [1:0]  bank_release;

   logic        a_rd_req, b_rd_req, m_rd_req;
   logic [31:0] a_rd_addr, b_rd_addr, m_rd_addr;
   logic        a_buf_we, b_buf_we, m_buf_we;
   logic        a_buf_bank, b_buf_bank, m_buf_bank;
   logic [9:0]  a_buf_addr, b_buf_addr, m_buf_addr;
   logic [7:0]  a_buf_wdata, b_buf_wdata, m_buf_wdata;
   logic [1:0]  a_bank_full, b_bank_full, m_bank_full;
   logic [15:0] a_frame_index, b_frame_index, m_frame_index;
   logic        a_playing, b_playing, m_playing;
   logic        a_fault, b_fault, m_fault;

   assign m_rd_req      = sel ? b_rd_req      : a_rd_req;
   assign m_rd_addr     = sel ? b_rd_addr     : a_rd_addr;
   assign m_buf_we      = sel ? b_buf_we      : a_buf_we;
   assign m_buf_bank    = sel ? b_buf_bank    : a_buf_bank;
   assign m_buf_addr    = sel ? b_buf_addr    : a_buf_addr;
   assign m_buf_wdata   = sel ? b_buf_wdata   : a_buf_wdata;
   assign m_bank_full   = sel ? b_bank_full   : a_bank_full;
   assign m_frame_index = sel ? b_frame_index : a_frame_index;
   assign m_playing     = sel ? b_playing     : a_playing;
   assign m_fault       = sel ? b_fault       : a_fault;

   sd_frame_fetch_sched #(
      .START_BLOCK (100), .BLOCKS_PER_FRAME (2), .NUM_FRAMES (3), .LOOP (0),
      .MAX_RETRIES (3), .BUF_ADDR_W (10)
   ) u_dut_a (
      .clk (clk), .reset (reset_a), .sd_ready (sd_ready_a),
      .rd_req (a_rd_req), .rd_addr (a_rd_addr), .rd_ack (rd_ack), .rd_data (rd_data),
      .rd_data_valid (rd_data_valid), .rd_done (rd_done), .rd_error (rd_error),
      .buf_we (a_buf_we), .buf_bank (a_buf_bank), .buf_addr (a_buf_addr),
      .buf_wdata (a_buf_wdata), .bank_full (a_bank_full), .bank_release (bank_release),
      .frame_index (a_frame_index), .playing (a_playing), .fault (a_fault)
   );

   sd_frame_fetch_sched #(
      .START_BLOCK (100), .BLOCKS_PER_FRAME (2), .NUM_FRAMES (2), .LOOP (1),
      .MAX_RETRIES (3), .BUF_ADDR_W (10)
   ) u_dut_b (
      .clk (clk), .reset (reset_b), .sd_ready (sd_ready_b),
      .rd_req (b_rd_req), .rd_addr (b_rd_addr), .rd_ack (rd_ack), .rd_data (rd_data),
      .rd_data_valid (rd_data_valid), .rd_done (rd_done), .rd_error (rd_error),
      .buf_we (b_buf_we), .buf_bank (b_buf_bank), .buf_addr (b_buf_addr),
      .buf_wdata (b_buf_wdata), .bank_full (b_bank_full), .bank_release (bank_release),
      .frame_index (b_frame_index), .playing (b_playing), .fault (b_fault)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int we_cnt = 0;
   logic [7:0] mem [2][1024];

   // Frame-buffer model fed by the observed write port.
   always @(negedge clk) begin
      if (m_buf_we === 1'b1) begin
         we_cnt <= we_cnt + 1;
         mem[m_buf_bank][m_buf_addr] <= m_buf_wdata;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (m_rd_req !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      check_eq("req_seen", 32'(m_rd_req), 32'd1);
   endtask

   // Acts as the bus master for one request: ack, nbytes of data, then done or error.
   task automatic serve(input int nbytes, input bit err, input logic [7:0] seed,
                        output logic [31:0] addr);
      wait_req();
      addr = m_rd_addr;
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      check_eq("req_drop", 32'(m_rd_req), 32'd0);
      for (int i = 0; i < nbytes; i++) begin
         rd_data       = seed + 8'(i);
         rd_data_valid = 1'b1;
         tick();
      end
      rd_data_valid = 1'b0;
      if (err) rd_error = 1'b1;
      else     rd_done  = 1'b1;
      tick();
      rd_error = 1'b0;
      rd_done  = 1'b0;
   endtask

   task automatic pulse_release(input logic [1:0] which);
      bank_release = which;
      tick();
      bank_release = 2'b00;
   endtask

   task automatic reset_a_pulse();
      reset_a = 1'b0;
      tick();
      reset_a = 1'b1;
   endtask

   logic [31:0] a;
   logic [1:0]  exp_full [3];
   int n, w0;

   initial begin
      sel = 1'b0; reset_a = 1'b0; reset_b = 1'b0; sd_ready_a = 1'b0; sd_ready_b = 1'b0;
      rd_ack = 1'b0; rd_data = 8'h00; rd_data_valid = 1'b0; rd_done = 1'b0; rd_error = 1'b0;
      bank_release = 2'b00;
      exp_full[0] = 2'b01; exp_full[1] = 2'b10; exp_full[2] = 2'b01;
      tick(); tick();

      check_eq("rst_rd_req", 32'(m_rd_req), 32'd0);
      check_eq("rst_rd_addr", m_rd_addr, 32'd0);
      check_eq("rst_buf_we", 32'(m_buf_we), 32'd0);
      check_eq("rst_buf_addr", 32'(m_buf_addr), 32'd0);
      check_eq("rst_bank_full", 32'(m_bank_full), 32'd0);
      check_eq("rst_frame_index", 32'(m_frame_index), 32'd0);
      check_eq("rst_playing", 32'(m_playing), 32'd0);
      check_eq("rst_fault", 32'(m_fault), 32'd0);

      // Nominal playback, three frames, prompt release, stop in DONE.
      reset_a = 1'b1;
      tick(); tick(); tick();
      check_eq("idle_no_ready", 32'(m_playing), 32'd0);
      sd_ready_a = 1'b1;
      tick();
      check_eq("playing_up", 32'(m_playing), 32'd1);
      for (int f = 0; f < 3; f++) begin
         for (int b = 0; b < 2; b++) begin
            w0 = we_cnt;
            serve(512, 1'b0, 8'(f * 16 + b), a);
            check_eq("t1_addr", a, 32'(100 + 2 * f + b));
            check_eq("t1_frame_index", 32'(m_frame_index), 32'(f));
            if (f == 0 && b == 0) check_eq("t1_we_count", 32'(we_cnt - w0), 32'd512);
         end
         tick();
         check_eq("t1_bank_full", 32'(m_bank_full), 32'(exp_full[f]));
         if (f < 2) pulse_release(2'(1 << (f % 2)));
      end
      check_eq("t1_done_playing", 32'(m_playing), 32'd0);
      tick(); tick();
      check_eq("t1_done_no_req", 32'(m_rd_req), 32'd0);

      // Retries on block 101, then no release so both banks fill.
      reset_a_pulse();
      serve(512, 1'b0, 8'h01, a);
      check_eq("t3_addr100", a, 32'd100);
      serve(100, 1'b1, 8'h10, a);
      check_eq("t3_try1", a, 32'd101);
      serve(100, 1'b1, 8'h20, a);
      check_eq("t3_try2", a, 32'd101);
      serve(512, 1'b0, 8'h30, a);
      check_eq("t3_try3", a, 32'd101);
      check_eq("t3_fault", 32'(m_fault), 32'd0);
      tick();
      check_eq("t3_mem_blk0", 32'(mem[0][5]), 32'h06);
      check_eq("t3_mem_blk1", 32'(mem[0][517]), 32'h35);
      check_eq("t3_mem_last", 32'(mem[0][1023]), 32'h2f);
      serve(512, 1'b0, 8'h40, a);
      check_eq("t2_addr102", a, 32'd102);
      serve(512, 1'b0, 8'h50, a);
      check_eq("t2_addr103", a, 32'd103);
      tick();
      check_eq("t2_both_full", 32'(m_bank_full), 32'd3);
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (m_rd_req === 1'b1) n++;
      end
      check_eq("t2_stall_no_req", 32'(n), 32'd0);
      pulse_release(2'b01);
      n = 0;
      while (m_rd_req !== 1'b1 && n < 5) begin
         tick();
         n++;
      end
      check_eq("t2_release_latency", 32'(n), 32'd1);
      check_eq("t2_addr104", m_rd_addr, 32'd104);

      // Four consecutive errors exhaust three retries.
      reset_a_pulse();
      for (int k = 0; k < 4; k++) begin
         serve(20, 1'b1, 8'(k), a);
         check_eq("t4_addr", a, 32'd100);
      end
      tick();
      check_eq("t4_fault", 32'(m_fault), 32'd1);
      check_eq("t4_playing", 32'(m_playing), 32'd0);
      w0 = we_cnt;
      n = 0;
      for (int i = 0; i < 300; i++) begin
         rd_data_valid = (i < 10);
         tick();
         if (m_rd_req === 1'b1) n++;
      end
      rd_data_valid = 1'b0;
      check_eq("t4_no_req", 32'(n), 32'd0);
      check_eq("t4_no_write", 32'(we_cnt - w0), 32'd0);
      check_eq("t4_fault_sticky", 32'(m_fault), 32'd1);

      // Short block and overlong block are both retried.
      reset_a_pulse();
      w0 = we_cnt;
      serve(511, 1'b0, 8'h00, a);
      check_eq("t5_short_addr", a, 32'd100);
      check_eq("t5_short_we", 32'(we_cnt - w0), 32'd511);
      w0 = we_cnt;
      serve(513, 1'b0, 8'h00, a);
      check_eq("t5_long_addr", a, 32'd100);
      check_eq("t5_long_we", 32'(we_cnt - w0), 32'd512);
      serve(512, 1'b0, 8'h00, a);
      check_eq("t5_good_addr", a, 32'd100);
      serve(512, 1'b0, 8'h00, a);
      check_eq("t5_next_addr", a, 32'd101);
      check_eq("t5_fault", 32'(m_fault), 32'd0);

      // Looping instance: wrap back to START_BLOCK, then async reset mid-RECV.
      reset_a = 1'b0;
      sel = 1'b1;
      reset_b = 1'b1;
      sd_ready_b = 1'b1;
      serve(512, 1'b0, 8'h00, a);
      check_eq("t6_addr100", a, 32'd100);
      serve(512, 1'b0, 8'h00, a);
      check_eq("t6_addr101", a, 32'd101);
      tick();
      check_eq("t6_full0", 32'(m_bank_full), 32'd1);
      pulse_release(2'b01);
      check_eq("t6_released", 32'(m_bank_full), 32'd0);
      serve(512, 1'b0, 8'h00, a);
      check_eq("t6_addr102", a, 32'd102);
      serve(512, 1'b0, 8'h00, a);
      check_eq("t6_addr103", a, 32'd103);
      tick();
      check_eq("t6_full1", 32'(m_bank_full), 32'd2);
      pulse_release(2'b01);
      check_eq("t6_rel_ignored", 32'(m_bank_full), 32'd2);
      serve(512, 1'b0, 8'h00, a);
      check_eq("t6_wrap_addr", a, 32'd100);
      check_eq("t6_wrap_frame", 32'(m_frame_index), 32'd0);
      wait_req();
      check_eq("t6_mid_addr", m_rd_addr, 32'd101);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      for (int i = 0; i < 10; i++) begin
         rd_data       = 8'(i);
         rd_data_valid = 1'b1;
         tick();
      end
      check_eq("t6_pre_we", 32'(m_buf_we), 32'd1);
      check_eq("t6_pre_full", 32'(m_bank_full), 32'd2);
      #2 reset_b = 1'b0;
      #1;
      check_eq("t6_async_we", 32'(m_buf_we), 32'd0);
      check_eq("t6_async_full", 32'(m_bank_full), 32'd0);
      check_eq("t6_async_req", 32'(m_rd_req), 32'd0);
      check_eq("t6_async_playing", 32'(m_playing), 32'd0);
      rd_data_valid = 1'b0;
      sd_ready_b = 1'b0;
      tick();
      reset_b = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check_eq("t6_wait_ready", 32'(m_playing), 32'd0);
      check_eq("t6_wait_req", 32'(m_rd_req), 32'd0);
      sd_ready_b = 1'b1;
      tick();
      check_eq("t6_restart", 32'(m_playing), 32'd1);
      serve(512, 1'b0, 8'h00, a);
      check_eq("t6_restart_addr", a, 32'd100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
